// File: rtl/branch_unit_arbiter.sv
// Round-robin shares one branch comparator among NUM_REQ issue slots; the result is registered, one cycle after grant.
// A held result that is not accepted blocks further grants; flush squashes it and blocks grants in that cycle.
module branch_unit_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int XLEN    = 32,
   parameter int TAG_W   = 5,
   parameter int CNT_W   = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*XLEN-1:0]  req_rs1,
   input  logic [NUM_REQ*XLEN-1:0]  req_rs2,
   input  logic [NUM_REQ*3-1:0]     req_func,
   input  logic [NUM_REQ-1:0]       req_pred_taken,
   input  logic [NUM_REQ*TAG_W-1:0] req_tag,
   output logic [NUM_REQ-1:0]       grant,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [TAG_W-1:0]         out_tag,
   output logic                     out_taken,
   output logic                     out_mispredict,
   output logic [CNT_W-1:0]         mispred_count
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [PTR_W:0] NREQ = (PTR_W+1)'(NUM_REQ);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] win_idx;
   logic [PTR_W-1:0] nxt_ptr;
   logic [PTR_W:0]   scan;
   logic             win_found;
   logic             accept;
   logic             do_grant;
   logic [XLEN-1:0]  sel_rs1;
   logic [XLEN-1:0]  sel_rs2;
   logic [2:0]       sel_func;
   logic             sel_pred;
   logic [TAG_W-1:0] sel_tag;
   logic             cmp_taken;

   assign accept = !flush && (!out_valid || out_ready);

   // Scan slots starting at rr_ptr, wrapping; first valid slot wins.
   always_comb begin
      scan      = '0;
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, rr_ptr} + (PTR_W+1)'(k);
         if (scan >= NREQ) begin
            scan = scan - NREQ;
         end
         if (!win_found && req_valid[scan[PTR_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = scan[PTR_W-1:0];
         end
      end
   end

   assign do_grant = accept && win_found;
   assign grant    = do_grant ? (NUM_REQ'(1) << win_idx) : '0;
   assign nxt_ptr  = (win_idx == LAST_IDX) ? '0 : win_idx + PTR_W'(1);

   assign sel_rs1  = req_rs1[win_idx*XLEN +: XLEN];
   assign sel_rs2  = req_rs2[win_idx*XLEN +: XLEN];
   assign sel_func = req_func[win_idx*3 +: 3];
   assign sel_pred = req_pred_taken[win_idx];
   assign sel_tag  = req_tag[win_idx*TAG_W +: TAG_W];

   always_comb begin
      cmp_taken = 1'b0;
      case (sel_func)
         3'b000:  cmp_taken = (sel_rs1 == sel_rs2);
         3'b001:  cmp_taken = (sel_rs1 != sel_rs2);
         3'b010:  cmp_taken = ($signed(sel_rs1) <  $signed(sel_rs2));
         3'b011:  cmp_taken = ($signed(sel_rs1) >= $signed(sel_rs2));
         3'b100:  cmp_taken = (sel_rs1 <  sel_rs2);
         3'b101:  cmp_taken = (sel_rs1 >= sel_rs2);
         default: cmp_taken = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid      <= 1'b0;
         out_tag        <= '0;
         out_taken      <= 1'b0;
         out_mispredict <= 1'b0;
         rr_ptr         <= '0;
      end else if (do_grant) begin
         out_valid      <= 1'b1;
         out_tag        <= sel_tag;
         out_taken      <= cmp_taken;
         out_mispredict <= cmp_taken ^ sel_pred;
         rr_ptr         <= nxt_ptr;
      end else if (flush || out_ready) begin
         out_valid      <= 1'b0;
      end
   end

   // Only results actually handed to the consumer are counted; a flushed one is not.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mispred_count <= '0;
      end else if (out_valid && out_ready && out_mispredict && !flush &&
                   (mispred_count != {CNT_W{1'b1}})) begin
         mispred_count <= mispred_count + 1'b1;
      end
   end

endmodule
